// File: rtl/lane_collision_monitor.sv
// lane_collision_monitor: detects frog/car collisions in one lane row and manages
// lives, the respawn pulse, the post-strike grace window and the sticky game-over level.
module lane_collision_monitor #(
    parameter int LIVES        = 3,
    parameter int LIFE_W       = 2,
    parameter int GRACE_CYCLES = 256,
    parameter int GRACE_W      = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       lane_pixels,
    input  logic [3:0]        frog_col,
    input  logic              frog_in_lane,
    output logic              hit,
    output logic              respawn,
    output logic [LIFE_W-1:0] lives
);
    typedef enum logic [1:0] {PLAY, GRACE, OVER} state_t;

    state_t              state_q, state_d;
    logic [LIFE_W-1:0]   lives_q, lives_d;
    logic [GRACE_W-1:0]  cnt_q, cnt_d;
    logic                hit_q, hit_d;
    logic                resp_q, resp_d;
    logic                collide;

    // Pixel bit 15 is the leftmost column, so the column index is mirrored.
    assign collide = frog_in_lane & lane_pixels[4'd15 - frog_col];

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        resp_d  = 1'b0;
        case (state_q)
            PLAY: begin
                if (collide && lives_q > LIFE_W'(1)) begin
                    state_d = GRACE;
                    lives_d = lives_q - LIFE_W'(1);
                    resp_d  = 1'b1;
                    cnt_d   = GRACE_W'(GRACE_CYCLES - 1);
                end else if (collide) begin
                    state_d = OVER;
                    lives_d = '0;
                    hit_d   = 1'b1;
                end
            end
            GRACE: begin
                state_d = (cnt_q == '0) ? PLAY : GRACE;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - GRACE_W'(1);
            end
            OVER: begin
                lives_d = '0;
                hit_d   = 1'b1;
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PLAY;
            lives_q <= LIFE_W'(LIVES);
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            resp_q  <= resp_d;
        end
    end

    assign hit     = hit_q;
    assign respawn = resp_q;
    assign lives   = lives_q;
endmodule

// File: tb/tb_lane_collision_monitor.sv
// tb_lane_collision_monitor: directed stimulus with a per-cycle reference model
// plus hand-computed literal checks.
module tb_lane_collision_monitor;
    localparam int G = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] lane_pixels = 16'hCCCC;
    logic [3:0]  frog_col = 4'd2;
    logic        frog_in_lane = 1'b1;
    logic        hit, respawn;
    logic [1:0]  lives;

    int n_checks = 0;
    int n_pass   = 0;

    lane_collision_monitor #(.LIVES(3), .LIFE_W(2), .GRACE_CYCLES(G), .GRACE_W(3)) dut (
        .clk(clk), .reset(reset), .lane_pixels(lane_pixels), .frog_col(frog_col),
        .frog_in_lane(frog_in_lane), .hit(hit), .respawn(respawn), .lives(lives)
    );

    always #5 clk = ~clk;

    // Reference: a strike costs a life (or ends the game on the last one), and
    // the G edges following a non-fatal strike are ignored.
    int m_lives = 3;
    int m_hit = 0;
    int m_resp = 0;
    int m_ignore = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lives = 3; m_hit = 0; m_resp = 0; m_ignore = 0;
        end else begin
            m_resp = 0;
            if (m_hit == 0) begin
                if (m_ignore > 0) m_ignore = m_ignore - 1;
                else if (frog_in_lane && lane_pixels[15 - int'(frog_col)]) begin
                    if (m_lives > 1) begin
                        m_lives = m_lives - 1; m_resp = 1; m_ignore = G;
                    end else begin
                        m_lives = 0; m_hit = 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    always @(negedge clk) begin
        check("model_hit", int'(hit), m_hit);
        check("model_respawn", int'(respawn), m_resp);
        check("model_lives", int'(lives), m_lives);
    end

    task automatic set_reset(input logic v);
        @(negedge clk);
        #2 reset = v;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        // No collision: bit 13 of CCCC is 0
        repeat (6) @(negedge clk);
        check("t1_lives", int'(lives), 3);
        check("t1_hit", int'(hit), 0);
        check("t1_resp", int'(respawn), 0);
        // Single-cycle strike at column 0
        frog_col = 4'd0;
        @(negedge clk);
        frog_col = 4'd2;
        check("t2_resp", int'(respawn), 1);
        check("t2_lives", int'(lives), 2);
        @(negedge clk);
        check("t2_resp_drop", int'(respawn), 0);
        repeat (G + 2) @(negedge clk);
        // Held collision from a fresh reset
        #2 reset = 1'b1;
        frog_col = 4'd0;
        set_reset(1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin check("t3_l1", int'(lives), 2); check("t3_r1", int'(respawn), 1); end
            if (k == 2) check("t3_r2", int'(respawn), 0);
            if (k == 5) check("t3_grace_lives", int'(lives), 2);
            if (k == 6) begin check("t3_l6", int'(lives), 1); check("t3_r6", int'(respawn), 1); end
            if (k == 10) check("t3_l10", int'(lives), 1);
            if (k == 11) begin check("t3_hit", int'(hit), 1); check("t3_l11", int'(lives), 0); end
            if (k == 12) check("t3_no_third", int'(respawn), 0);
        end
        // Activity while game over
        for (int k = 0; k < 6; k++) begin
            frog_col = 4'(k * 3);
            frog_in_lane = k[0];
            lane_pixels = (k[1]) ? 16'hFFFF : 16'h0000;
            @(negedge clk);
        end
        check("t5_hit", int'(hit), 1);
        check("t5_lives", int'(lives), 0);
        // Asynchronous reset between edges
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_async_hit", int'(hit), 0);
        check("t5_async_lives", int'(lives), 3);
        set_reset(1'b0);
        // Frog outside the lane never collides
        frog_in_lane = 1'b0;
        lane_pixels = 16'hFFFF;
        for (int c = 0; c < 16; c++) begin
            frog_col = 4'(c);
            @(negedge clk);
        end
        check("t4_lives", int'(lives), 3);
        check("t4_hit", int'(hit), 0);
        // Reset in the middle of the grace window
        frog_in_lane = 1'b1;
        frog_col = 4'd0;
        @(negedge clk);
        frog_col = 4'd1;
        check("t6_strike", int'(lives), 2);
        @(negedge clk);
        #2 reset = 1'b1;
        frog_col = 4'd0;
        @(negedge clk);
        check("t6_reset_lives", int'(lives), 3);
        #2 reset = 1'b0;
        @(negedge clk);
        check("t6_post_lives", int'(lives), 2);
        check("t6_post_resp", int'(respawn), 1);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
